// File: rtl/sandbox_host_link.sv
// Host-side framing engine: assembles 8-byte request frames from the UART receive stream,
// hands them to the sandbox process, and serializes the 8-byte response back to the host.
module sandbox_host_link #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        masterClock,
    input  logic        reset,
    input  logic        rxValid,
    input  logic [7:0]  rxByte,
    output logic        txValid,
    output logic [7:0]  txByte,
    input  logic        txReady,
    output logic        dataReceived,
    output logic [7:0]  control,
    output logic [55:0] inputData,
    input  logic        clearDR,
    input  logic        transmitData,
    input  logic [7:0]  status,
    input  logic [55:0] outputData,
    output logic        frameError,
    output logic        overrun
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {COLLECT, DELIVER, SEND, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [7:0]         rx_buf_q [7];
    logic [55:0]        frame_data;
    logic [63:0]        tx_shift_q;
    logic [7:0]         control_q;
    logic [55:0]        input_data_q;
    logic               frame_error_q;
    logic               overrun_q;

    logic rx_accept, tx_accept, last_rx, last_tx, timeout_hit;

    assign rx_accept = (state_q == COLLECT) && rxValid;
    assign tx_accept = (state_q == SEND) && txReady;
    assign last_rx   = rx_accept && (cnt_q == 3'd7);
    assign last_tx   = tx_accept && (cnt_q == 3'd7);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == COLLECT) && (cnt_q != 3'd0)
                         && !rxValid && ((32'(idle_q) + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) state_q <= COLLECT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (last_rx) state_d = DELIVER;
            DELIVER: if (clearDR) state_d = transmitData ? SEND : RELEASE;
            SEND:    if (last_tx) state_d = RELEASE;
            RELEASE: if (!clearDR) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        txValid      = (state_q == SEND);
        dataReceived = (state_q == DELIVER);
        txByte       = tx_shift_q[7:0];
        control      = control_q;
        inputData    = input_data_q;
        frameError   = frame_error_q;
        overrun      = overrun_q;
    end

    // The byte counter wraps 7->0 on the last byte, so SEND always starts at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (rx_accept || tx_accept) cnt_d = cnt_q + 3'd1;
        if (timeout_hit || (state_q == RELEASE && !clearDR)) cnt_d = 3'd0;
    end

    always_comb begin
        idle_d = idle_q;
        if (state_q != COLLECT || cnt_q == 3'd0 || rxValid || timeout_hit)
            idle_d = '0;
        else if (idle_q != {IDLE_W{1'b1}})
            idle_d = idle_q + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_slot
            always_ff @(posedge masterClock or posedge reset) begin
                if (reset)
                    rx_buf_q[gi] <= 8'h00;
                else if (rx_accept && cnt_q == 3'(gi))
                    rx_buf_q[gi] <= rxByte;
            end
        end
        for (gi = 1; gi < 7; gi++) begin : g_frame
            assign frame_data[(gi-1)*8 +: 8] = rx_buf_q[gi];
        end
    endgenerate
    assign frame_data[55:48] = rxByte;

    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            cnt_q         <= 3'd0;
            idle_q        <= '0;
            tx_shift_q    <= 64'h0;
            control_q     <= 8'h00;
            input_data_q  <= 56'h0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idle_q        <= idle_d;
            frame_error_q <= timeout_hit;
            overrun_q     <= rxValid && (state_q != COLLECT);
            if (last_rx) begin
                control_q    <= rx_buf_q[0];
                input_data_q <= frame_data;
            end
            if (state_q == DELIVER && clearDR && transmitData)
                tx_shift_q <= {outputData, status};
            else if (tx_accept)
                tx_shift_q <= {8'h00, tx_shift_q[63:8]};
        end
    end

endmodule

// File: doc/sandbox_host_link.md
# sandbox_host_link

Host-side framing and handshake engine that sits between the UART byte interface and the sandbox process. It assembles 8-byte request frames (one control byte plus a 56-bit data word) from the receive byte stream and presents them with the `dataReceived`/`clearDR` handshake. It captures the process's `status` and `outputData` when `transmitData` is asserted, then serializes them back to the host as an 8-byte response frame.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000: inter-byte timeout in `masterClock` cycles for a partial request frame; 0 disables the timeout.

Ports:
- `masterClock`  in  1  sole operating clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rxValid`  in  1  one-cycle strobe from the UART receiver indicating `rxByte` is valid.
- `rxByte`  in  8  received byte.
- `txValid`  out  1  indicates `txByte` is offered to the UART transmitter.
- `txByte`  out  8  byte to transmit.
- `txReady`  in  1  transmitter accepts `txByte` in any cycle where `txValid` and `txReady` are both 1.
- `dataReceived`  out  1  a complete request is held on `control`/`inputData`.
- `control`  out  8  request control byte.
- `inputData`  out  56  request data word.
- `clearDR`  in  1  the process has consumed the request.
- `transmitData`  in  1  the process requests transmission of `status`/`outputData`.
- `status`  in  8  response status byte.
- `outputData`  in  56  response data word.
- `frameError`  out  1  one-cycle pulse when a partial frame is discarded on timeout.
- `overrun`  out  1  one-cycle pulse when a received byte is dropped.

## Operation
- Request frame byte order: byte 0 is `control`; bytes 1–7 are `inputData[7:0]` through `inputData[55:48]` (least-significant byte first).
- Response frame byte order: byte 0 is `status`; bytes 1–7 are `outputData[7:0]` through `outputData[55:48]`.
- **COLLECT** (entered on reset):
  - A 3-bit byte counter starts at 0.
  - Each `rxValid` shifts `rxByte` into its slot and increments the counter.
  - On the 8th byte, load `control`/`inputData`, set `dataReceived`, and go to DELIVER.
- **DELIVER**:
  - `control`/`inputData` are held stable.
  - When `clearDR` is sampled 1 with `transmitData` = 1: latch `{outputData, status}` into a 64-bit transmit shift register, clear `dataReceived`, and go to SEND.
  - When `clearDR` is sampled 1 with `transmitData` = 0: clear `dataReceived` and go to RELEASE. No response is sent.
- **SEND**:
  - `txValid` = 1 and `txByte` = the current low byte of the shift register.
  - On each accept, shift right by 8 and increment the byte counter.
  - After the 8th accept, drop `txValid` and go to RELEASE.
- **RELEASE**: when `clearDR` is sampled 0, reset the byte counter and go to COLLECT.
- **Dropped bytes**: `rxValid` in any state other than COLLECT drops the byte and pulses `overrun`.
- **Timeout**:
  - Applies only in COLLECT with byte counter > 0.
  - An idle counter increments each cycle without `rxValid` and clears on `rxValid`.
  - When it reaches `TIMEOUT_CYCLES`: discard the partial frame, reset the byte counter to 0, and pulse `frameError`.
  - Idle counter width is $clog2(TIMEOUT_CYCLES+1) bits; it saturates and does not wrap.
- **Simultaneous events**:
  - `rxValid` in the cycle the timeout would expire: the byte is accepted, no error is raised, and the timer clears.
  - `clearDR` and `transmitData` rising in the same cycle: treated as `transmitData` = 1.
- **Reset mid-operation**: aborts any frame or transmission immediately; state returns to COLLECT with counters at 0.
- **Reset values**: `txValid`, `txByte`, `dataReceived`, `control`, `inputData`, `frameError`, and `overrun` are all 0.

## Timing
- `dataReceived` rises on the edge that samples the 8th `rxValid`; `control`/`inputData` are valid in that same cycle.
- `dataReceived` falls on the edge that samples `clearDR` = 1.
- `txValid` rises on the same edge, with byte 0 presented.
- After an accept, the next byte is presented in the following cycle, giving one byte per cycle at full throughput.
- Under `txReady` = 0, `txByte` and `txValid` are held unchanged.
- The RELEASE→COLLECT transition takes 1 cycle after `clearDR` is sampled 0. Bytes that arrive before the transition are dropped with `overrun`.
- `frameError` and `overrun` are registered and last exactly 1 cycle per event.
- Reset assertion forces all outputs to their reset values asynchronously. Operation resumes on the first clock edge after deassertion.

## Test plan
- **Request assembly:** rxBytes A5,01,02,03,04,05,06,07 → `control` = 0xA5, `inputData` = 0x07060504030201, `dataReceived` = 1 in the cycle after the last byte.
- **Response path:** a process model holds `transmitData` = 1 with `status` = 0x3C and `outputData` = 0x11223344556677, then raises `clearDR` → `dataReceived` drops on the next edge, and tx bytes are 3C,77,66,55,44,33,22,11 in order.
- **Backpressure:** `txReady` is held 0 for 5 cycles during byte 3 → `txByte` holds 0x55 throughout, with no byte lost or duplicated; exactly 8 accepts in total.
- **Timeout:** with `TIMEOUT_CYCLES` = 16, send 3 bytes then idle 16 cycles → one `frameError` pulse; the next 8 bytes form a correct frame.
- **No response / overrun:** `clearDR` without `transmitData` → zero tx accepts and return to COLLECT. An `rxValid` sent during DELIVER → one `overrun` pulse and the next frame is unaffected.
- **Reset mid-frame:** assert `reset` during tx byte 4 → all outputs read 0 immediately; the following request frame assembles correctly.
